kitchen_countdown: RTL

- Consumer side of the kitchen-timer tick prescaler. Takes its single-cycle tick pulse, nominally 1 Hz, and counts down a user-set mm:ss value held in BCD.
- Signals an alarm when the count reaches 00:00.
- Sits between the debounced push-button logic, the tick prescaler and the 7-segment display driver.

---
 rtl/kitchen_timer_pkg.sv | 14 +
 rtl/bcd2_counter.sv | 66 ++++++
 rtl/kitchen_countdown.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/kitchen_timer_pkg.sv
// Shared types and constants for the kitchen countdown timer.
package kitchen_timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] SEC_WRAP_TENS = 4'd5;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up/down counter. The tens digit wraps at TENS_MAX, so the
// counter cycles {TENS_MAX,9} -> 00 going up and 00 -> {TENS_MAX,9} going down.
// borrow is combinational: high while dec is requested on 00.
// clr beats dec, and dec beats inc.
module bcd2_counter
    import kitchen_timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] TENS_MAX = 4'd9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic               dec,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               borrow
);

    logic [DIGIT_W-1:0] tens_d;
    logic [DIGIT_W-1:0] ones_d;

    assign borrow = dec && (tens == '0) && (ones == '0);

    // Next digit values with BCD carry/borrow between ones and tens.
    always_comb begin
        tens_d = tens;
        ones_d = ones;
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (dec) begin
            if (ones != '0) begin
                ones_d = ones - 4'd1;
            end else if (tens != '0) begin
                ones_d = 4'd9;
                tens_d = tens - 4'd1;
            end else begin
                ones_d = 4'd9;
                tens_d = TENS_MAX;
            end
        end else if (inc) begin
            if (ones != 4'd9) begin
                ones_d = ones + 4'd1;
            end else if (tens != TENS_MAX) begin
                ones_d = '0;
                tens_d = tens + 4'd1;
            end else begin
                ones_d = '0;
                tens_d = '0;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else begin
            tens <= tens_d;
            ones <= ones_d;
        end
    end

endmodule

// File: rtl/kitchen_countdown.sv
// Kitchen timer countdown: mm:ss in BCD, counted down on the 1 Hz tick,
// with an alarm phase that auto-returns to SET after ALARM_SECS ticks.
// Build option: define KITCHEN_COUNTDOWN_BLINK_EN to blink the display
// (blank toggles each tick) while the alarm is active.
//
// Every input pulse is a single-cycle strobe. In one cycle only the
// highest-priority pulse acts: btn_clr > btn_start > tick > btn_min/btn_sec;
// btn_min and btn_sec share a level and may both act together.
module kitchen_countdown
    import kitchen_timer_pkg::*;
#(
    parameter int ALARM_SECS   = 10,
    parameter int MAX_MIN_TENS = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               btn_min,
    input  logic               btn_sec,
    input  logic               btn_start,
    input  logic               btn_clr,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running,
    output logic               alarm,
    output logic               blank
);

    localparam logic [7:0]         ALARM_LIMIT = 8'(ALARM_SECS);
    localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = DIGIT_W'(MAX_MIN_TENS);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] acnt_q;
    logic [7:0] acnt_d;
    logic       clr_time;
    logic       sec_inc;
    logic       sec_dec;
    logic       min_inc;
    logic       sec_borrow;

    // Prioritised events: at most one level acts per cycle.
    logic ev_clr;
    logic ev_start;
    logic ev_tick;
    logic ev_min;
    logic ev_sec;
    assign ev_clr   = btn_clr;
    assign ev_start = !btn_clr && btn_start;
    assign ev_tick  = !btn_clr && !btn_start && tick;
    assign ev_min   = !btn_clr && !btn_start && !tick && btn_min;
    assign ev_sec   = !btn_clr && !btn_start && !tick && btn_sec;

    logic time_zero;
    logic time_one;
    assign time_zero = (min_tens == '0) && (min_ones == '0) &&
                       (sec_tens == '0) && (sec_ones == '0);
    assign time_one  = (min_tens == '0) && (min_ones == '0) &&
                       (sec_tens == '0) && (sec_ones == 4'd1);

    bcd2_counter #(.TENS_MAX(SEC_WRAP_TENS)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_time),
        .inc    (sec_inc),
        .dec    (sec_dec),
        .tens   (sec_tens),
        .ones   (sec_ones),
        .borrow (sec_borrow)
    );

    // Minutes only ever move down when seconds roll from 00 to 59.
    bcd2_counter #(.TENS_MAX(MIN_TENS_MAX)) u_min (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_time),
        .inc    (min_inc),
        .dec    (sec_borrow),
        .tens   (min_tens),
        .ones   (min_ones),
        .borrow ()
    );

    // Next state, alarm counter and digit-counter controls.
    always_comb begin
        state_d  = state_q;
        acnt_d   = acnt_q;
        clr_time = 1'b0;
        sec_inc  = 1'b0;
        sec_dec  = 1'b0;
        min_inc  = 1'b0;
        case (state_q)
            ST_SET: begin
                if (ev_clr) begin
                    clr_time = 1'b1;
                end else if (ev_start) begin
                    if (!time_zero) state_d = ST_RUN;
                end else begin
                    min_inc = ev_min;
                    sec_inc = ev_sec;
                end
            end
            ST_RUN: begin
                if (ev_clr) begin
                    clr_time = 1'b1;
                    state_d  = ST_SET;
                end else if (ev_start) begin
                    state_d = ST_PAUSE;
                end else if (ev_tick) begin
                    sec_dec = 1'b1;
                    if (time_one) begin
                        state_d = ST_ALARM;
                        acnt_d  = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (ev_clr) begin
                    clr_time = 1'b1;
                    state_d  = ST_SET;
                end else if (ev_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (ev_clr || ev_start) begin
                    clr_time = 1'b1;
                    state_d  = ST_SET;
                end else if (ev_tick) begin
                    acnt_d = acnt_q + 8'd1;
                    if (acnt_q + 8'd1 == ALARM_LIMIT) state_d = ST_SET;
                end
            end
            default: state_d = ST_SET;
        endcase
    end

    // State, alarm counter and the status flags registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SET;
            acnt_q  <= '0;
            running <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            running <= (state_d == ST_RUN);
            alarm   <= (state_d == ST_ALARM);
        end
    end

`ifdef KITCHEN_COUNTDOWN_BLINK_EN
    logic blank_q;
    logic blank_d;

    // Blank starts set on alarm entry, toggles each alarm tick, clears on exit.
    always_comb begin
        blank_d = 1'b0;
        if (state_d == ST_ALARM) begin
            if (state_q != ST_ALARM) blank_d = 1'b1;
            else if (ev_tick)        blank_d = ~blank_q;
            else                     blank_d = blank_q;
        end
    end

    // Blink register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) blank_q <= 1'b0;
        else     blank_q <= blank_d;
    end

    assign blank = blank_q;
`else
    assign blank = 1'b0;
`endif

endmodule
